// File: rtl/lsu_mem_master.sv
// Load/store initiator for a byte-masked, word-indexed data memory port.
// Optional LSU_BOUND_CHECK_EN rejects requests whose word index is >= MEM_DEPTH.
module lsu_mem_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 512
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [2:0]          i_req_funct3,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  output logic                o_mem_wren,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

`ifdef LSU_BOUND_CHECK_EN
  localparam logic BOUND_EN = 1'b1;
`else
  localparam logic BOUND_EN = 1'b0;
`endif

  function automatic logic req_legal(input logic we, input logic [1:0] off, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~off[0];
      3'b010:         ok = (off == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok & ~(we & f3[2]);
  endfunction

  function automatic logic [DATA_W/8-1:0] lane_mask(input logic [1:0] off, input logic [2:0] f3);
    logic [DATA_W/8-1:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] off, input logic [2:0] f3,
                                                   input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    case (f3[1:0])
      2'b00:   r = {{(DATA_W-8){1'b0}}, w[7:0]} << {off, 3'b000};
      2'b01:   r = {{(DATA_W-16){1'b0}}, w[15:0]} << {off, 3'b000};
      2'b10:   r = w;
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [1:0] off, input logic [2:0] f3,
                                                    input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    s = rd >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{(DATA_W-8){s[7]}}, s[7:0]};
      3'b001:  r = {{(DATA_W-16){s[15]}}, s[15:0]};
      3'b010:  r = s;
      3'b100:  r = {{(DATA_W-8){1'b0}}, s[7:0]};
      3'b101:  r = {{(DATA_W-16){1'b0}}, s[15:0]};
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_bmask_q, mem_bmask_d;
  logic                mem_wren_q, mem_wren_d;
  logic                we_q, we_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   word_idx_s;
  logic                in_range_s;

  // Word index of the incoming request and its optional range qualification.
  always_comb begin
    word_idx_s = {2'b00, i_req_addr[ADDR_W-1:2]};
    in_range_s = ~BOUND_EN | (word_idx_s < ADDR_W'(MEM_DEPTH));
  end

  // Next-state logic; memory-port outputs are zero unless the next cycle is ACCESS.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    mem_bmask_d = {(DATA_W/8){1'b0}};
    mem_wren_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = i_req_we;
          off_d       = i_req_addr[1:0];
          funct3_d    = i_req_funct3;
          if (req_legal(i_req_we, i_req_addr[1:0], i_req_funct3) && in_range_s) begin
            state_d     = S_ACCESS;
            mem_addr_d  = word_idx_s;
            mem_bmask_d = lane_mask(i_req_addr[1:0], i_req_funct3);
            mem_wdata_d = lane_wdata(i_req_addr[1:0], i_req_funct3, i_req_wdata);
            mem_wren_d  = i_req_we;
          end else begin
            // Rejected requests skip the memory and answer one cycle after acceptance.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        if (we_q) begin
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          rsp_rdata_d = load_extend(off_q, funct3_q, i_mem_rdata);
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = {DATA_W{1'b0}};
          rsp_err_d   = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = {DATA_W{1'b0}};
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset also drops an in-flight write strobe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_bmask_q <= {(DATA_W/8){1'b0}};
      mem_wren_q  <= 1'b0;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      mem_wren_q  <= mem_wren_d;
      we_q        <= we_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-masked memory model and a response scoreboard.
module tb_lsu_mem_master;

  logic        clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:511];
  int          checks;
  int          failures;

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(512)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_funct3(i_req_funct3),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .o_mem_wren(o_mem_wren), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: masked byte writes on the clock edge, unmasked lanes read as zero.
  always @(posedge clk) begin
    if (o_mem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_bmask[b]) mem[o_mem_addr[8:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    i_mem_rdata = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (o_mem_bmask[b]) i_mem_rdata[8*b +: 8] = mem[o_mem_addr[8:0]][8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_bmask, input logic [31:0] exp_mwdata,
                        input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({name, ":req_ready_idle"}, {31'b0, o_req_ready}, 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_addr   = addr;
    i_req_funct3 = f3;
    i_req_wdata  = wdata;
    sb_q.push_back('{err: exp_err, rdata: exp_rdata});
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    lat = 1;
    if (!exp_err) begin
      chk({name, ":acc_addr"}, o_mem_addr, addr >> 2);
      chk({name, ":acc_bmask"}, {28'b0, o_mem_bmask}, {28'b0, exp_bmask});
      chk({name, ":acc_wdata"}, o_mem_wdata, exp_mwdata);
      chk({name, ":acc_wren"}, {31'b0, o_mem_wren}, {31'b0, we});
      chk({name, ":acc_rsp_valid"}, {31'b0, o_rsp_valid}, 32'd0);
      chk({name, ":acc_req_ready"}, {31'b0, o_req_ready}, 32'd0);
    end
    while (!o_rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ":rsp_valid"}, {31'b0, o_rsp_valid}, 32'd1);
    chk({name, ":latency"}, lat, exp_err ? 32'd1 : 32'd2);
    chk({name, ":post_wren"}, {31'b0, o_mem_wren}, 32'd0);
    chk({name, ":post_bmask"}, {28'b0, o_mem_bmask}, 32'd0);
    chk({name, ":post_addr"}, o_mem_addr, 32'd0);
    e = sb_q.pop_front();
    chk({name, ":rdata"}, o_rsp_rdata, e.rdata);
    chk({name, ":err"}, {31'b0, o_rsp_err}, {31'b0, e.err});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, ":hold_valid"}, {31'b0, o_rsp_valid}, 32'd1);
      chk({name, ":hold_rdata"}, o_rsp_rdata, e.rdata);
      chk({name, ":hold_req_ready"}, {31'b0, o_req_ready}, 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    chk({name, ":done_valid"}, {31'b0, o_rsp_valid}, 32'd0);
    chk({name, ":done_req_ready"}, {31'b0, o_req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    i_req_we = 1'b0;
    i_req_addr = 32'h0;
    i_req_funct3 = 3'b000;
    i_req_wdata = 32'h0;
    i_rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("rst_rdata", o_rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, o_rsp_err}, 32'd0);
    chk("rst_mem_wren", {31'b0, o_mem_wren}, 32'd0);
    chk("rst_mem_bmask", {28'b0, o_mem_bmask}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    @(negedge clk);
    i_reset = 1'b0;

    do_req("sw_10",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF, 0);
    do_req("sb_13",  1'b1, 32'h13, 3'b000, 32'h123456A5, 1'b0, 32'h0, 4'b1000, 32'hA5000000, 0);
    do_req("lb_13",  1'b0, 32'h13, 3'b000, 32'h0, 1'b0, 32'hFFFFFFA5, 4'b1000, 32'h0, 0);
    do_req("lbu_13", 1'b0, 32'h13, 3'b100, 32'h0, 1'b0, 32'h000000A5, 4'b1000, 32'h0, 0);
    do_req("lb_11",  1'b0, 32'h11, 3'b000, 32'h0, 1'b0, 32'hFFFFFFBE, 4'b0010, 32'h0, 0);
    do_req("lhu_10", 1'b0, 32'h10, 3'b101, 32'h0, 1'b0, 32'h0000BEEF, 4'b0011, 32'h0, 0);
    do_req("lh_12",  1'b0, 32'h12, 3'b001, 32'h0, 1'b0, 32'hFFFFA5AD, 4'b1100, 32'h0, 0);
    do_req("sh_22",  1'b1, 32'h22, 3'b001, 32'hFFFF8001, 1'b0, 32'h0, 4'b1100, 32'h80010000, 0);
    do_req("lh_22",  1'b0, 32'h22, 3'b001, 32'h0, 1'b0, 32'hFFFF8001, 4'b1100, 32'h0, 0);
    do_req("lhu_22", 1'b0, 32'h22, 3'b101, 32'h0, 1'b0, 32'h00008001, 4'b1100, 32'h0, 0);
    do_req("lw_hold", 1'b0, 32'h10, 3'b010, 32'h0, 1'b0, 32'hA5ADBEEF, 4'b1111, 32'h0, 5);
    do_req("lw_mis",  1'b0, 32'h06, 3'b010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    do_req("sh_mis",  1'b1, 32'h05, 3'b001, 32'hFFFF, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    do_req("sbu_ill", 1'b1, 32'h10, 3'b100, 32'h55, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    do_req("f3_011",  1'b0, 32'h10, 3'b011, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 2);

    // Reset in the middle of a store's ACCESS cycle.
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_addr = 32'h30;
    i_req_funct3 = 3'b010;
    i_req_wdata = 32'h11111111;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    chk("rst_mid:wren_before", {31'b0, o_mem_wren}, 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_mid:wren_dropped", {31'b0, o_mem_wren}, 32'd0);
    chk("rst_mid:bmask", {28'b0, o_mem_bmask}, 32'd0);
    chk("rst_mid:req_ready", {31'b0, o_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_mid:no_rsp", {31'b0, o_rsp_valid}, 32'd0);
    end
    chk("rst_mid:idle_ready", {31'b0, o_req_ready}, 32'd1);
    do_req("lw_30", 1'b0, 32'h30, 3'b010, 32'h0, 1'b0, 32'h0, 4'b1111, 32'h0, 0);
    do_req("lw_10", 1'b0, 32'h10, 3'b010, 32'h0, 1'b0, 32'hA5ADBEEF, 4'b1111, 32'h0, 0);
`ifdef LSU_BOUND_CHECK_EN
    do_req("lw_oob", 1'b0, 32'h800, 3'b010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    do_req("lw_last", 1'b0, 32'h7FC, 3'b010, 32'h0, 1'b0, 32'h0, 4'b1111, 32'h0, 0);
`endif
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the byte-masked, word-indexed data memory port (addr/wdata/bmask/wren in, combinational rdata out).
- Accepts one CPU load/store request at a time over a valid/ready handshake and decodes RV32 funct3 into a byte mask.
- Write data is lane-shifted; read data is lane-extracted and sign/zero-extended.
- Sits between the pipeline MEM stage and the data memory instance.

Parameters:
ADDR_W, 32, width of request byte address and of memory word-index output
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
MEM_DEPTH, 512, number of words in the attached memory (used only by the optional bound check)

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, asynchronous, active-high
i_req_valid  input  1  request present
o_req_ready  output  1  block can accept a request
i_req_we  input  1  1=store, 0=load
i_req_addr  input  ADDR_W  byte address
i_req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
i_req_wdata  input  DATA_W  store data, right-aligned
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  consumer accepts response
o_rsp_rdata  output  DATA_W  extended load data (0 for stores/errors)
o_rsp_err  output  1  misaligned/illegal/out-of-range request
o_mem_addr  output  ADDR_W  word index = registered byte address >> 2
o_mem_wdata  output  DATA_W  lane-shifted store data
o_mem_bmask  output  DATA_W/8  byte-lane mask
o_mem_wren  output  1  write strobe
i_mem_rdata  input  DATA_W  memory read data (unmasked lanes read 0)

Behaviour:
- Reset (async): state=IDLE; o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, all o_mem_* = 0.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE: o_req_ready=1.
  - On i_req_valid&o_req_ready, register we/addr/funct3/wdata.
  - Legal request -> ACCESS; illegal request -> RESP with err=1.
- Legality:
  - funct3 in {011,110,111} illegal.
  - Store with funct3[2]=1 illegal.
  - H/HU with addr[0]=1 illegal.
  - W with addr[1:0]!=0 illegal.
- ACCESS (exactly 1 cycle), off = addr[1:0]:
  - o_mem_addr=addr>>2.
  - bmask: B -> 4'b0001<<off; H -> 4'b0011<<off; W -> 4'b1111.
  - o_mem_wdata = wdata<<(8*off), B/H upper bits of wdata ignored.
  - Store: o_mem_wren=1 this cycle only.
  - Load: o_mem_wren=0; capture i_mem_rdata>>(8*off) at the closing edge; sign-extend (B/H) or zero-extend (BU/HU) into o_rsp_rdata.
- Outside ACCESS: o_mem_wren=0, o_mem_bmask=0, o_mem_addr=0, o_mem_wdata=0.
- RESP:
  - o_rsp_valid=1; o_rsp_rdata/o_rsp_err held stable until i_rsp_ready.
  - Leave on i_rsp_ready -> IDLE.
  - o_req_ready=0 in ACCESS and RESP; no request overlap.
- Latency: request accepted at edge N; ACCESS during cycle N+1; o_rsp_valid from cycle N+2; minimum 3 cycles per transaction.
- Error path: accepted at N, o_rsp_valid at N+1, rdata=0, err=1, no memory activity (wren/bmask never asserted).
- Store response: rdata=0, err=0.
- Reset mid-operation: immediate return to IDLE.
  - Reset asserted during ACCESS drops wren asynchronously.
  - Write is not guaranteed committed; pending response discarded.
- i_req_valid while not ready: ignored; requester must hold it.

Optional Feature:
- Macro LSU_BOUND_CHECK_EN.
- Defined: a request with (addr>>2) >= MEM_DEPTH is treated as illegal (err=1, no access, error-path timing).
- Undefined: no range check; o_mem_addr is addr>>2 unmodified; out-of-range behaviour is the memory's.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF -> ACCESS: o_mem_addr=4, bmask=1111, wren=1 for one cycle; response err=0, rdata=0 at cycle N+2.
- SB addr=0x13 wdata=0x000000A5, then LB addr=0x13 -> store bmask=1000, o_mem_wdata=0xA5000000; load rdata=0xFFFFFFA5; LBU same addr -> 0x000000A5.
- SH addr=0x22 wdata=0x8001, then LH/LHU addr=0x22 -> bmask=1100; LH rdata=0xFFFF8001, LHU rdata=0x00008001.
- LW addr=0x06 and SH addr=0x05 -> err=1 at N+1, rdata=0, wren/bmask stay 0; SB with funct3=100 -> err=1.
- Hold i_rsp_ready=0 for 5 cycles after LW -> o_rsp_valid/rdata stable, o_req_ready=0; release -> back to IDLE next cycle.
- Assert i_reset during ACCESS of SW -> wren drops same cycle, o_rsp_valid never asserts, o_req_ready=1. With LSU_BOUND_CHECK_EN, LW addr=0x800 (index 512) -> err=1.
